risc_exec_ctrl: RTL and testbench
=================================

Name: risc_exec_ctrl

Overview:
- Multi-cycle sequencing FSM for the RISC execute datapath.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and latches its opcode.
- Generates per-cycle datapath controls: operand reads, immediate muxing, flag latching, ALU start and regfile write.
- Sits between the instruction latch and the datapath/regfile; keeps a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_OPC, 8'hFF, opcode that halts the controller
RET_OPC, 8'h08, return opcode (restores popped flags)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
instrn  input  32  instruction from fetch/instruction latch
instrn_valid  input  1  instrn holds a valid instruction
instrn_ready  output  1  controller can accept an instruction
ld_instrn  output  1  load instrn into the current-instruction latch
reset_aluregs  output  1  clear ALU operand registers
rd_oprnd_a  output  1  load ALU operand A register
rd_oprnd_b  output  1  load ALU operand B register
usedata_imm_or_regb  output  1  operand B source: 1 = immediate, 0 = regfile port B
usedata_imm_or_alu  output  1  regfile write source: 1 = immediate, 0 = ALU result
latch_flags  output  1  latch popped PSW flags
alu_start  output  1  start ALU operation
flag_we  output  1  update architectural flags from ALU
wr_regfile  output  1  regfile port C write enable
retire  output  1  one-cycle pulse per retired instruction
retire_cnt  output  CNT_W  retired-instruction count
halted  output  1  controller in HALT

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high, sampled only on the rising edge of clk.
- States: IDLE, READ, EXEC, WB, HALT. State, latched opcode and retire_cnt are the only registers.
- All outputs are Moore decodes of state plus the latched opcode, except ld_instrn.
- Opcode is instrn[7:0], latched on accept. Class is opc[7:6]:
  - 01: reg-reg ALU.
  - 10: reg-imm ALU.
  - 11: load-immediate.
  - 00: control (NOP, return). Any 00-class opcode other than RET_OPC behaves as NOP.
  - HALT_OPC overrides its class.
- IDLE:
  - instrn_ready=1.
  - Accept when instrn_valid&instrn_ready: ld_instrn=1 (combinational, same cycle), opcode latched, next state READ.
  - If instrn_valid=0, stay in IDLE. ld_instrn is never asserted outside IDLE.
- READ (1 cycle):
  - rd_oprnd_a=rd_oprnd_b=1 for classes 01/10.
  - usedata_imm_or_regb=1 for class 10 only.
  - If HALT_OPC: next state HALT. Otherwise: next state EXEC.
- EXEC:
  - alu_start=1 in the first EXEC cycle for classes 01/10.
  - latch_flags=1 when opcode==RET_OPC.
  - Next state WB.
- WB (1 cycle):
  - wr_regfile=1 for classes 01/10/11.
  - usedata_imm_or_alu=1 for class 11.
  - flag_we=1 for classes 01/10.
  - retire=1. retire_cnt increments, wrapping from all-ones to 0.
  - Next state IDLE.
- Latency: accept to retire is 3 cycles; accept to next instrn_ready is 4 cycles.
- HALT:
  - halted=1, instrn_ready=0, reset_aluregs=1, all other controls 0.
  - Leaves HALT only via reset. HALT does not retire.
- reset_aluregs=1 while reset is high and while in HALT; 0 otherwise.
- Reset, including mid-instruction: next state IDLE, retire_cnt=0, latched opcode=0.
  - All outputs 0 except reset_aluregs=1 during reset and instrn_ready=1 once in IDLE.
  - An in-flight instruction is dropped: no wr_regfile, no retire.
- Control outputs not listed for a state are 0.

Optional Feature:
- Macro: MULTICYCLE_ALU_EN.
- Defined:
  - Adds input alu_done (1 bit).
  - EXEC remains until alu_done=1 is sampled in EXEC, including the first EXEC cycle.
  - alu_start pulses only in the first EXEC cycle.
  - Only classes 01/10 wait; other classes leave EXEC after 1 cycle regardless of alu_done.
- Not defined:
  - alu_done port absent; EXEC is always exactly 1 cycle.

Test Plan:
- Reset, then idle with valid=0 -> instrn_ready=1, retire_cnt=0, all controls 0, reset_aluregs=0 after reset drops.
- Accept opc 8'h40 (reg-reg) at cycle 0 -> ld_instrn@0; rd_oprnd_a/b@1 with imm_or_regb=0; alu_start@2; wr_regfile, flag_we, retire@3; ready@4; retire_cnt=1.
- opc 8'h80 (reg-imm) -> imm_or_regb=1 in READ. opc 8'hC0 (load-imm) -> no operand reads, no alu_start, usedata_imm_or_alu=1 and wr_regfile=1 in WB, flag_we=0.
- opc 8'h08 -> latch_flags=1 in EXEC only, no wr_regfile, retire=1. opc 8'hFF -> HALT after READ: halted=1, ready=0 for 20 cycles, retire_cnt unchanged; reset -> IDLE.
- Reset asserted during EXEC of 8'h40 -> next cycle IDLE, no wr_regfile/retire. Preload 2^CNT_W-1 retires -> next retire wraps retire_cnt to 0.
- MULTICYCLE_ALU_EN defined, opc 8'h40, alu_done low 5 EXEC cycles -> alu_start once, WB on cycle after alu_done=1; opc 8'hC0 ignores alu_done.

Source files
------------

// File: rtl/risc_exec_ctrl.sv
// risc_exec_ctrl: multi-cycle sequencing FSM for the RISC execute datapath.
// Accepts one instruction per valid/ready handshake, latches its opcode and
// walks IDLE -> READ -> EXEC -> WB, decoding per-cycle datapath controls
// from the current state and the latched opcode. A HALT opcode parks the
// controller in HALT until reset.
// Optional build macro: MULTICYCLE_ALU_EN adds the alu_done input and lets
// ALU-class instructions stay in EXEC until the ALU reports completion.
module risc_exec_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [7:0]  HALT_OPC = 8'hFF,
    parameter logic [7:0]  RET_OPC  = 8'h08
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrn,
    input  logic             instrn_valid,
`ifdef MULTICYCLE_ALU_EN
    input  logic             alu_done,
`endif
    output logic             instrn_ready,
    output logic             ld_instrn,
    output logic             reset_aluregs,
    output logic             rd_oprnd_a,
    output logic             rd_oprnd_b,
    output logic             usedata_imm_or_regb,
    output logic             usedata_imm_or_alu,
    output logic             latch_flags,
    output logic             alu_start,
    output logic             flag_we,
    output logic             wr_regfile,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted
);

    // S_EXEC_WAIT holds ALU-class instructions after their first EXEC cycle;
    // it is only reachable when the multi-cycle ALU option is built in.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_EXEC      = 3'd2,
        S_WB        = 3'd3,
        S_HALT      = 3'd4,
        S_EXEC_WAIT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         opc_q;
    logic [CNT_W-1:0]   retire_cnt_q;

    logic [1:0]         opc_class;
    logic               is_halt;
    logic               is_alu;
    logic               is_imm_alu;
    logic               is_ldi;
    logic               is_ret;
    logic               accept;
    logic               unused_instrn_hi;

    // Only the opcode byte is consumed here; operand fields go to the datapath.
    assign unused_instrn_hi = ^instrn[31:8];

    // Opcode class decode; the HALT opcode overrides whatever class it encodes.
    assign opc_class  = opc_q[7:6];
    assign is_halt    = (opc_q == HALT_OPC);
    assign is_alu     = !is_halt && ((opc_class == 2'b01) || (opc_class == 2'b10));
    assign is_imm_alu = !is_halt && (opc_class == 2'b10);
    assign is_ldi     = !is_halt && (opc_class == 2'b11);
    assign is_ret     = (opc_q == RET_OPC);

    // Handshake: the only control that responds to inputs in the same cycle.
    assign accept    = (state_q == S_IDLE) && !reset && instrn_valid;
    assign ld_instrn = accept;

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_READ;
            S_READ: state_d = is_halt ? S_HALT : S_EXEC;
`ifdef MULTICYCLE_ALU_EN
            S_EXEC:      state_d = (!is_alu || alu_done) ? S_WB : S_EXEC_WAIT;
            S_EXEC_WAIT: state_d = alu_done ? S_WB : S_EXEC_WAIT;
`else
            S_EXEC: state_d = S_WB;
`endif
            S_WB:   state_d = S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State, opcode latch and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            opc_q        <= 8'h00;
            retire_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) opc_q <= instrn[7:0];
            if (state_q == S_WB) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_cnt_q;

    // Moore control decode; everything is quiet while reset is held.
    always_comb begin
        instrn_ready        = 1'b0;
        reset_aluregs       = reset || (state_q == S_HALT);
        rd_oprnd_a          = 1'b0;
        rd_oprnd_b          = 1'b0;
        usedata_imm_or_regb = 1'b0;
        usedata_imm_or_alu  = 1'b0;
        latch_flags         = 1'b0;
        alu_start           = 1'b0;
        flag_we             = 1'b0;
        wr_regfile          = 1'b0;
        retire              = 1'b0;
        halted              = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: instrn_ready = 1'b1;
                S_READ: begin
                    rd_oprnd_a          = is_alu;
                    rd_oprnd_b          = is_alu;
                    usedata_imm_or_regb = is_imm_alu;
                end
                S_EXEC: begin
                    alu_start   = is_alu;
                    latch_flags = is_ret;
                end
                S_WB: begin
                    wr_regfile         = is_alu || is_ldi;
                    usedata_imm_or_alu = is_ldi;
                    flag_we            = is_alu;
                    retire             = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_exec_ctrl.sv
// Directed self-checking bench for risc_exec_ctrl.
// Control outputs are packed into one vector and compared cycle by cycle
// against hand-derived expectations. Define MULTICYCLE_ALU_EN for both the
// design and this bench to exercise the alu_done wait path.
module tb_risc_exec_ctrl;

    localparam int unsigned CW = 8;

    // Bit positions of the packed control vector.
    localparam logic [12:0] RDY  = 13'h1000;
    localparam logic [12:0] LD   = 13'h0800;
    localparam logic [12:0] RSTA = 13'h0400;
    localparam logic [12:0] RA   = 13'h0200;
    localparam logic [12:0] RB   = 13'h0100;
    localparam logic [12:0] IMMB = 13'h0080;
    localparam logic [12:0] IMMA = 13'h0040;
    localparam logic [12:0] LF   = 13'h0020;
    localparam logic [12:0] ALU  = 13'h0010;
    localparam logic [12:0] FWE  = 13'h0008;
    localparam logic [12:0] WR   = 13'h0004;
    localparam logic [12:0] RET  = 13'h0002;
    localparam logic [12:0] HLT  = 13'h0001;
    localparam logic [12:0] NONE = 13'h0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instrn;
    logic          instrn_valid;
    logic          alu_done;
    logic          instrn_ready, ld_instrn, reset_aluregs, rd_oprnd_a, rd_oprnd_b;
    logic          usedata_imm_or_regb, usedata_imm_or_alu, latch_flags, alu_start;
    logic          flag_we, wr_regfile, retire, halted;
    logic [CW-1:0] retire_cnt;
    logic [12:0]   ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    risc_exec_ctrl #(
        .CNT_W    (CW),
        .HALT_OPC (8'hFF),
        .RET_OPC  (8'h08)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .instrn              (instrn),
        .instrn_valid        (instrn_valid),
`ifdef MULTICYCLE_ALU_EN
        .alu_done            (alu_done),
`endif
        .instrn_ready        (instrn_ready),
        .ld_instrn           (ld_instrn),
        .reset_aluregs       (reset_aluregs),
        .rd_oprnd_a          (rd_oprnd_a),
        .rd_oprnd_b          (rd_oprnd_b),
        .usedata_imm_or_regb (usedata_imm_or_regb),
        .usedata_imm_or_alu  (usedata_imm_or_alu),
        .latch_flags         (latch_flags),
        .alu_start           (alu_start),
        .flag_we             (flag_we),
        .wr_regfile          (wr_regfile),
        .retire              (retire),
        .retire_cnt          (retire_cnt),
        .halted              (halted)
    );

    assign ctl = {instrn_ready, ld_instrn, reset_aluregs, rd_oprnd_a, rd_oprnd_b,
                  usedata_imm_or_regb, usedata_imm_or_alu, latch_flags, alu_start,
                  flag_we, wr_regfile, retire, halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and check accept/READ/EXEC/WB/IDLE control vectors.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic hold,
                             input logic [12:0] e_rd, input logic [12:0] e_ex,
                             input logic [12:0] e_wb);
        instrn = ins;
        instrn_valid = 1'b1;
        #1 chk({tag, ".acc"}, 32'(ctl), 32'(RDY | LD));
        tick();
        instrn_valid = hold;
        #1 chk({tag, ".read"}, 32'(ctl), 32'(e_rd));
        tick();
        #1 chk({tag, ".exec"}, 32'(ctl), 32'(e_ex));
        tick();
        #1 chk({tag, ".wb"}, 32'(ctl), 32'(e_wb));
        tick();
        instrn_valid = 1'b0;
        #1 chk({tag, ".idle"}, 32'(ctl), 32'(RDY));
    endtask

    initial begin
        reset        = 1'b1;
        instrn       = 32'h0;
        instrn_valid = 1'b0;
        alu_done     = 1'b1;

        // Reset: only reset_aluregs active.
        tick();
        #1 chk("rst.ctl", 32'(ctl), 32'(RSTA));
        chk("rst.cnt", 32'(retire_cnt), 32'd0);
        tick();
        reset = 1'b0;
        #1 chk("idle.ctl", 32'(ctl), 32'(RDY));
        chk("idle.cnt", 32'(retire_cnt), 32'd0);
        tick();
        tick();
        #1 chk("idle2.ctl", 32'(ctl), 32'(RDY));

        // One instruction of each class; upper instrn bits must be ignored.
        run_instr("rr40", 32'hDEAD_BE40, 1'b0, RA | RB, ALU, WR | FWE | RET);
        chk("rr40.cnt", 32'(retire_cnt), 32'd1);
        run_instr("ri80", 32'h0000_0080, 1'b1, RA | RB | IMMB, ALU, WR | FWE | RET);
        chk("ri80.cnt", 32'(retire_cnt), 32'd2);
        run_instr("ldC0", 32'h1234_56C0, 1'b0, NONE, NONE, WR | IMMA | RET);
        run_instr("ret08", 32'h0000_0008, 1'b0, NONE, LF, RET);
        run_instr("nop17", 32'hFFFF_FF17, 1'b1, NONE, NONE, RET);
        run_instr("rr7F", 32'h0000_007F, 1'b0, RA | RB, ALU, WR | FWE | RET);
        run_instr("riBF", 32'h0000_00BF, 1'b0, RA | RB | IMMB, ALU, WR | FWE | RET);
        chk("seq.cnt", 32'(retire_cnt), 32'd7);

        // HALT: parks for good, valid held high must not be accepted.
        instrn = 32'h0000_00FF;
        instrn_valid = 1'b1;
        #1 chk("halt.acc", 32'(ctl), 32'(RDY | LD));
        tick();
        #1 chk("halt.read", 32'(ctl), 32'(NONE));
        for (int i = 0; i < 20; i++) begin
            tick();
            #1 chk("halt.park", 32'(ctl), 32'(HLT | RSTA));
        end
        chk("halt.cnt", 32'(retire_cnt), 32'd7);
        instrn_valid = 1'b0;
        reset = 1'b1;
        #1 chk("halt.rst", 32'(ctl), 32'(RSTA));
        tick();
        reset = 1'b0;
        #1 chk("halt.out", 32'(ctl), 32'(RDY));
        chk("halt.cnt0", 32'(retire_cnt), 32'd0);

        // Reset during EXEC drops the instruction.
        instrn = 32'h0000_0040;
        instrn_valid = 1'b1;
        #1 chk("mid.acc", 32'(ctl), 32'(RDY | LD));
        tick();
        instrn_valid = 1'b0;
        #1 chk("mid.read", 32'(ctl), 32'(RA | RB));
        tick();
        #1 chk("mid.exec", 32'(ctl), 32'(ALU));
        reset = 1'b1;
        #1 chk("mid.rst", 32'(ctl), 32'(RSTA));
        tick();
        reset = 1'b0;
        #1 chk("mid.idle", 32'(ctl), 32'(RDY));
        tick();
        #1 chk("mid.idle2", 32'(ctl), 32'(RDY));
        chk("mid.cnt", 32'(retire_cnt), 32'd0);

        // Counter wrap: 255 retires, then one more returns to zero.
        for (int i = 0; i < 255; i++) begin
            instrn = 32'h0000_0000;
            instrn_valid = 1'b1;
            tick();
            instrn_valid = 1'b0;
            tick();
            tick();
            tick();
        end
        chk("wrap.full", 32'(retire_cnt), 32'd255);
        run_instr("wrap", 32'h0000_0000, 1'b0, NONE, NONE, RET);
        chk("wrap.cnt", 32'(retire_cnt), 32'd0);

`ifdef MULTICYCLE_ALU_EN
        // ALU class waits for alu_done; alu_start only in the first EXEC cycle.
        alu_done = 1'b0;
        instrn = 32'h0000_0040;
        instrn_valid = 1'b1;
        #1 chk("mc.acc", 32'(ctl), 32'(RDY | LD));
        tick();
        instrn_valid = 1'b0;
        #1 chk("mc.read", 32'(ctl), 32'(RA | RB));
        tick();
        #1 chk("mc.exec1", 32'(ctl), 32'(ALU));
        for (int i = 0; i < 4; i++) begin
            tick();
            #1 chk("mc.wait", 32'(ctl), 32'(NONE));
        end
        tick();
        alu_done = 1'b1;
        #1 chk("mc.done", 32'(ctl), 32'(NONE));
        tick();
        alu_done = 1'b0;
        #1 chk("mc.wb", 32'(ctl), 32'(WR | FWE | RET));
        tick();
        #1 chk("mc.idle", 32'(ctl), 32'(RDY));
        run_instr("mcC0", 32'h0000_00C0, 1'b0, NONE, NONE, WR | IMMA | RET);
        chk("mc.cnt", 32'(retire_cnt), 32'd2);
        alu_done = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
